axi_rom_responder: RTL

- AXI4 read-only responder (slave) serving the instruction-fetch side of the core: cache-line refill bursts and single-beat uncached fetches.
- Backed by a synchronous single-read-port word RAM with one-cycle read latency, plus a backdoor write port used by simulation and boot loaders.
- Sits between the interconnect and on-chip boot memory.
- Supports one outstanding transaction, full-rate streaming under rready backpressure, and error responses.

---
 rtl/axi_rom_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axi_rom_responder.sv
// AXI4 read-only responder for instruction fetch: bursts served from a one-cycle-latency word RAM
// through a 2-entry output FIFO, with a backdoor write port for preload.
module axi_rom_responder #(
    parameter int unsigned MEM_ADDR_W = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h1fc0_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           araddr_i,
    input  logic [7:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    input  logic [1:0]            arburst_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [31:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic                  mem_we_i,
    input  logic [MEM_ADDR_W-1:0] mem_waddr_i,
    input  logic [31:0]           mem_wdata_i
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam int unsigned     HiW    = 30 - MEM_ADDR_W;
    localparam logic [HiW-1:0] BaseHi = BASE_ADDR[31:MEM_ADDR_W+2];
    localparam int unsigned     Depth  = 2 ** MEM_ADDR_W;

    // Burst context
    logic [0:0]  state_q, state_d;
    logic        arready_q, arready_d;
    logic [29:0] cur_q, cur_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic        slverr_q, slverr_d;
    logic [8:0]  issue_rem_q, issue_rem_d;

    // Output FIFO
    logic [31:0] fifo_data_q [2];
    logic [1:0]  fifo_resp_q [2];
    logic        fifo_last_q [2];
    logic        rptr_q, wptr_q;
    logic [1:0]  cnt_q;

    // In-flight read: RAM output plus the beat attributes captured at issue
    logic        inflight_q;
    logic [1:0]  if_resp_q;
    logic        if_last_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] mem_q [Depth];

    logic        ar_hs;
    logic        pop;
    logic        issue;
    logic        wrap_legal;
    logic        in_range;
    logic        beat_last;
    logic [1:0]  beat_resp;
    logic [2:0]  occupancy;
    logic [29:0] wrap_mask;
    logic [29:0] cur_next;
    logic [31:0] push_data;
    logic        unused_araddr_lsb;

    assign unused_araddr_lsb = ^araddr_i[1:0];

    assign arready_o = arready_q;
    assign rvalid_o  = (cnt_q != 2'd0);
    assign rdata_o   = fifo_data_q[rptr_q];
    assign rresp_o   = fifo_resp_q[rptr_q];
    assign rlast_o   = rvalid_o && fifo_last_q[rptr_q];

    assign ar_hs = arvalid_i && arready_q;
    assign pop   = rvalid_o && rready_i;

    // Entries held plus the read about to land must leave room for the new read.
    assign occupancy = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == StBurst) && (issue_rem_q != 9'd0) && (occupancy < 3'd2);

    assign wrap_legal = (arlen_i == 8'd1) || (arlen_i == 8'd3) ||
                        (arlen_i == 8'd7) || (arlen_i == 8'd15);

    assign in_range  = (cur_q[29:MEM_ADDR_W] == BaseHi);
    assign beat_resp = slverr_q ? RespSlvErr : (in_range ? RespOkay : RespDecErr);
    assign beat_last = (issue_rem_q == 9'd1);
    assign wrap_mask = {22'd0, len_q};
    assign push_data = (if_resp_q == RespOkay) ? mem_rdata_q : 32'd0;

    always_comb begin
        case (burst_q)
            BurstFixed: cur_next = cur_q;
            BurstWrap:  cur_next = (cur_q & ~wrap_mask) | ((cur_q + 30'd1) & wrap_mask);
            default:    cur_next = cur_q + 30'd1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        len_d       = len_q;
        burst_d     = burst_q;
        slverr_d    = slverr_q;
        issue_rem_d = issue_rem_q;
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    cur_d       = araddr_i[31:2];
                    len_d       = arlen_i;
                    burst_d     = arburst_i;
                    slverr_d    = (arsize_i != 3'd2) || (arburst_i == BurstRsvd) ||
                                  ((arburst_i == BurstWrap) && !wrap_legal);
                    issue_rem_d = {1'b0, arlen_i} + 9'd1;
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                if (issue) begin
                    cur_d       = cur_next;
                    issue_rem_d = issue_rem_q - 9'd1;
                end
                if (pop && rlast_o) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign arready_d = (state_d == StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            arready_q      <= 1'b0;
            cur_q          <= '0;
            len_q          <= '0;
            burst_q        <= '0;
            slverr_q       <= 1'b0;
            issue_rem_q    <= '0;
            inflight_q     <= 1'b0;
            if_resp_q      <= '0;
            if_last_q      <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_resp_q[0] <= '0;
            fifo_resp_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            rptr_q         <= 1'b0;
            wptr_q         <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            cur_q       <= cur_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            slverr_q    <= slverr_d;
            issue_rem_q <= issue_rem_d;
            inflight_q  <= issue;
            if (issue) begin
                if_resp_q <= beat_resp;
                if_last_q <= beat_last;
            end
            if (inflight_q) begin
                fifo_data_q[wptr_q] <= push_data;
                fifo_resp_q[wptr_q] <= if_resp_q;
                fifo_last_q[wptr_q] <= if_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // Storage is not reset; a same-cycle read and write to one word returns the old word.
    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem_q[mem_waddr_i] <= mem_wdata_i;
        end
        if (issue) begin
            mem_rdata_q <= mem_q[cur_q[MEM_ADDR_W-1:0]];
        end
    end

endmodule
